mc_control_fsm: RTL
===================

Name: mc_control_fsm

Overview:
- Multicycle control unit that sequences the word-addressed MIPS-subset datapath.
- Samples the 6-bit opcode from the instruction register and drives every datapath control strobe.
- Also drives memory, register-file, PC-enable and mux selects, as a Moore FSM.
- Adds run/step gating at instruction boundaries, a HALT opcode, illegal-opcode flagging and a retired-instruction counter for board debug.

Parameters:
OP_RTYPE  6'b000000  R-type opcode
OP_LW     6'b100011  load word
OP_SW     6'b101011  store word
OP_BEQ    6'b000100  branch if equal
OP_J      6'b000010  jump
OP_ADDI   6'b001000  add immediate
OP_HALT   6'b111111  stop sequencing
CNT_W     16         width of instr_count

Ports:
clk          in   1      clock, all state on rising edge
reset        in   1      asynchronous, active-high; returns FSM to FETCH, clears counter/flags
opCode       in   6      IR opcode field
run          in   1      when 0, FSM holds in FETCH; when 1, instructions proceed
PCWriteCond  out  1      PC write if ALU zero
PCWrite      out  1      unconditional PC write
IorD         out  1      0=PC, 1=ALU result as memory address
MemRead      out  1      memory read strobe
MemWrite     out  1      memory write enable
MemtoReg     out  1      0=ALU result, 1=memory data to register file
IRWrite      out  1      IR load enable
PCSource     out  2      00=ALU result, 01=ALU register, 10=jump target
ALUOp        out  2      00=add, 01=subtract, 10=use funct field
ALUSrcB      out  2      00=B, 01=const 1, 10=sign-ext imm, 11=imm<<2
ALUSrcA      out  1      0=PC, 1=A
RegWrite     out  1      register file write enable
RegDst       out  1      0=rt, 1=rd
state        out  4      current state encoding, for HEX display
halted       out  1      1 while in HALT
illegal_op   out  1      one-cycle pulse on unknown opcode
instr_count  out  CNT_W  instructions fetched since reset

Behaviour:
- Moore outputs. Any strobe not listed for a state is 0; unlisted selects are 00/0.
- State encodings:
  - FETCH=0, FETCH_IR=1, DECODE=2, MEMADR=3, MEMWB=4, MEMWR=5, EXEC=6
  - ALUWB=7, ADDIEX=8, ADDIWB=9, BRANCH=10, JUMP=11, HALT=12
- FETCH: IorD=0, MemRead=1. Memory is synchronous, so this cycle only registers the address.
  - run=1: next FETCH_IR.
  - run=0: stay in FETCH.
- FETCH_IR: MemRead=1, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, PCWrite=1 (PC<=PC+1). instr_count increments. Next DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=10, ALUOp=00; the ALU register captures the branch target PC+imm. Dispatch on opCode:
  - LW, SW -> MEMADR
  - RTYPE -> EXEC
  - ADDI -> ADDIEX
  - BEQ -> BRANCH
  - J -> JUMP
  - HALT -> HALT
  - anything else -> FETCH, with illegal_op=1 for exactly the DECODE->FETCH cycle (registered pulse, asserted the cycle after DECODE).
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00, IorD=1, MemRead=1. Next MEMWB if LW, MEMWR if SW.
- MEMWB: ALU selects as MEMADR, IorD=1, MemtoReg=1, RegDst=0, RegWrite=1. Next FETCH.
- MEMWR: ALU selects as MEMADR, IorD=1, MemWrite=1. Next FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next ALUWB.
- ALUWB: EXEC selects held (write data is the combinational ALU result), RegDst=1, MemtoReg=0, RegWrite=1. Next FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next ADDIWB.
- ADDIWB: ADDIEX selects held, RegDst=0, RegWrite=1. Next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PCWriteCond=1. Next FETCH.
- JUMP: PCSource=10, PCWrite=1. Next FETCH.
- HALT: all strobes 0, halted=1. Stays in HALT until reset; run is ignored.
- Latencies: J 4 cycles; BEQ 4; R-type, ADDI, LW, SW 5 each.
- run is sampled only in FETCH. Deasserting run mid-instruction completes the instruction, then holds in FETCH.
- reset (async, any state, including mid-MEMWR) forces:
  - state=FETCH, with FETCH outputs immediately (MemRead=1, rest 0)
  - instr_count=0, illegal_op=0, halted=0
- instr_count wraps modulo 2^CNT_W.
- opCode is only sampled in DECODE and MEMADR. It is stable there because IRWrite=0 outside FETCH_IR.

Test Plan:
- Reset asserted mid-EXEC, async, no clock edge -> state=0, RegWrite=0, MemRead=1, instr_count=0 immediately.
- run=1, opCode=000000 -> state sequence 0,1,2,6,7,0. In state 7: RegWrite=1, RegDst=1, ALUOp=10. instr_count=1.
- opCode=100011 then 101011 -> LW sequence 0,1,2,3,4 with MemtoReg=1 in 4. SW sequence 0,1,2,3,5 with MemWrite=1 only in 5. instr_count=2.
- opCode=000100 -> BRANCH: PCWriteCond=1, PCSource=01, ALUOp=01, PCWrite=0. opCode=000010 -> JUMP: PCWrite=1, PCSource=10.
- opCode=010101 -> DECODE returns to FETCH, illegal_op high exactly one cycle. opCode=111111 -> halted=1 and state stays 12 for 20 cycles with run=1.
- run=0 -> state holds 0 for 10 cycles, IRWrite never 1. Then run=1 for one cycle -> exactly one instruction executes. Preload instr_count to 16'hFFFF, one fetch -> 0.

Source files
------------

// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
// mc_control_fsm : Moore control unit for the multicycle MIPS-subset datapath
// Revision 1.0   : initial release
// ============================================================================
module mc_control_fsm #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_HALT  = 6'b111111,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opCode,
  input  logic             run,
  output logic             PCWriteCond,
  output logic             PCWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic [1:0]       PCSource,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ALUSrcB,
  output logic             ALUSrcA,
  output logic             RegWrite,
  output logic             RegDst,
  output logic [3:0]       state,
  output logic             halted,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_FETCH_IR = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEMADR   = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_EXEC     = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_ADDIEX   = 4'd8;
  localparam logic [3:0] S_ADDIWB   = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_HALT     = 4'd12;

  logic [3:0]       r_state;
  logic [3:0]       w_next_state;
  logic             r_illegal;
  logic [CNT_W-1:0] r_count;
  logic             w_known_op;

  assign w_known_op = (opCode == OP_RTYPE) || (opCode == OP_LW) || (opCode == OP_SW) ||
                      (opCode == OP_BEQ) || (opCode == OP_J) || (opCode == OP_ADDI) ||
                      (opCode == OP_HALT);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:    w_next_state = run ? S_FETCH_IR : S_FETCH;
      S_FETCH_IR: w_next_state = S_DECODE;
      S_DECODE: begin
        if ((opCode == OP_LW) || (opCode == OP_SW)) w_next_state = S_MEMADR;
        else if (opCode == OP_RTYPE)                w_next_state = S_EXEC;
        else if (opCode == OP_ADDI)                 w_next_state = S_ADDIEX;
        else if (opCode == OP_BEQ)                  w_next_state = S_BRANCH;
        else if (opCode == OP_J)                    w_next_state = S_JUMP;
        else if (opCode == OP_HALT)                 w_next_state = S_HALT;
        else                                        w_next_state = S_FETCH;
      end
      S_MEMADR:   w_next_state = (opCode == OP_LW) ? S_MEMWB : S_MEMWR;
      S_EXEC:     w_next_state = S_ALUWB;
      S_ADDIEX:   w_next_state = S_ADDIWB;
      S_HALT:     w_next_state = S_HALT;
      default:    w_next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
      r_count   <= '0;
    end else begin
      r_state   <= w_next_state;
      // Pulse lands on the cycle the FSM is back in FETCH after a bad DECODE
      r_illegal <= (r_state == S_DECODE) && !w_known_op;
      if (r_state == S_FETCH_IR) r_count <= r_count + CNT_W'(1);
    end
  end

  always_comb begin
    PCWriteCond = 1'b0;
    PCWrite     = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    ALUSrcB     = 2'b00;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    case (r_state)
      S_FETCH: MemRead = 1'b1;
      S_FETCH_IR: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = 1'b1;
      end
      S_DECODE: ALUSrcB = 2'b10;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_MEMWB: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = 2'b10;
        IorD     = 1'b1;
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = 2'b10;
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 2'b10;
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = 2'b10;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCSource    = 2'b01;
        PCWriteCond = 1'b1;
      end
      S_JUMP: begin
        PCSource = 2'b10;
        PCWrite  = 1'b1;
      end
      default: ;
    endcase
  end

  assign state       = r_state;
  assign halted      = (r_state == S_HALT);
  assign illegal_op  = r_illegal;
  assign instr_count = r_count;

endmodule
`default_nettype wire
